// File: rtl/game369_pkg.sv
// game369_pkg
// Shared definitions for the 369-game stream checker.
//   - V0..V13   : the five legal count words of the 369 chant.
//   - state_t   : lock state of the checker (UNLOCKED / ACQUIRE / LOCKED).
//   - next_369  : successor of a legal word (0->3->6->9->13->6); illegal -> 0.
//   - is_legal_369 / is_clap_369 : value classification helpers.
package game369_pkg;

   localparam logic [3:0] V0  = 4'd0;
   localparam logic [3:0] V3  = 4'd3;
   localparam logic [3:0] V6  = 4'd6;
   localparam logic [3:0] V9  = 4'd9;
   localparam logic [3:0] V13 = 4'd13;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      ACQUIRE  = 2'd1,
      LOCKED   = 2'd2
   } state_t;

   function automatic logic [3:0] next_369(input logic [3:0] v);
      logic [3:0] n;
      case (v)
         V0:      n = V3;
         V3:      n = V6;
         V6:      n = V9;
         V9:      n = V13;
         V13:     n = V6;   // after the first round the chant restarts at 6
         default: n = V0;
      endcase
      return n;
   endfunction

   function automatic logic is_legal_369(input logic [3:0] v);
      return (v == V0) || (v == V3) || (v == V6) || (v == V9) || (v == V13);
   endfunction

   function automatic logic is_clap_369(input logic [3:0] v);
      return (v == V3) || (v == V6) || (v == V9) || (v == V13);
   endfunction

endpackage

// File: rtl/game369_checker.sv
// game369_checker
// Receiving-end checker for a 369-game count stream. Seeds on any legal
// word, acquires lock after LOCK_LEN consecutive matches, flywheels through
// isolated errors while locked and drops lock after MISS_LIMIT consecutive
// misses. All outputs are registered (one cycle after the sampling edge).
//
// Ports:
//   clk          in   sole clock, rising edge
//   reset        in   synchronous active-high reset
//   count_in     in   [3:0] observed count word
//   count_valid  in   sample qualifier
//   locked       out  registered state is LOCKED
//   match_pulse  out  sample equalled the expected word
//   error_pulse  out  sample mismatched in ACQUIRE or LOCKED
//   clap         out  sample was 3, 6, 9 or 13
//   round_cnt    out  [CNT_W-1:0] matched 13s while LOCKED, wraps
//   err_cnt      out  [CNT_W-1:0] total mismatches, saturates
//   state_dbg    out  current lock state, for observation only
//
// Stream handshake: count_in is consumed on every rising edge where
// count_valid is high; there is no back-pressure (the checker is always
// ready). When count_valid is low nothing advances and all pulses are 0.
module game369_checker
   import game369_pkg::*;
#(
   parameter int LOCK_LEN   = 2,
   parameter int MISS_LIMIT = 3,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       count_in,
   input  logic             count_valid,
   output logic             locked,
   output logic             match_pulse,
   output logic             error_pulse,
   output logic             clap,
   output logic [CNT_W-1:0] round_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output state_t           state_dbg
);

   localparam logic [3:0] LOCK_LEN_W   = 4'(LOCK_LEN);
   localparam logic [3:0] MISS_LIMIT_W = 4'(MISS_LIMIT);

   state_t     state;
   logic [3:0] exp_val;
   logic [3:0] hits;
   logic [3:0] misses;

   logic       legal;
   logic       hit;
   logic [3:0] hits_inc;
   logic [3:0] misses_inc;

   assign legal      = is_legal_369(count_in);
   assign hit        = (count_in == exp_val);
   assign hits_inc   = hits + 4'd1;
   assign misses_inc = misses + 4'd1;

   assign locked    = (state == LOCKED);
   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= UNLOCKED;
         exp_val     <= V0;
         hits        <= 4'd0;
         misses      <= 4'd0;
         match_pulse <= 1'b0;
         error_pulse <= 1'b0;
         clap        <= 1'b0;
         round_cnt   <= '0;
         err_cnt     <= '0;
      end else begin
         match_pulse <= 1'b0;
         error_pulse <= 1'b0;
         clap        <= 1'b0;
         if (count_valid) begin
            clap <= is_clap_369(count_in);
            case (state)
               UNLOCKED: begin
                  // Illegal words are noise here: no error is charged.
                  if (legal) begin
                     exp_val <= next_369(count_in);
                     hits    <= 4'd0;
                     state   <= ACQUIRE;
                  end
               end
               ACQUIRE: begin
                  if (hit) begin
                     match_pulse <= 1'b1;
                     hits        <= hits_inc;
                     exp_val     <= next_369(exp_val);
                     if (hits_inc == LOCK_LEN_W) begin
                        state  <= LOCKED;
                        misses <= 4'd0;
                     end
                  end else begin
                     error_pulse <= 1'b1;
                     if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
                     hits <= 4'd0;
                     if (legal) begin
                        // Re-seed from the observed word and start counting again.
                        exp_val <= next_369(count_in);
                     end else begin
                        state <= UNLOCKED;
                     end
                  end
               end
               LOCKED: begin
                  // Flywheel: the expectation advances whether or not we hit.
                  exp_val <= next_369(exp_val);
                  if (hit) begin
                     match_pulse <= 1'b1;
                     misses      <= 4'd0;
                     if (count_in == V13) round_cnt <= round_cnt + CNT_W'(1);
                  end else begin
                     error_pulse <= 1'b1;
                     if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
                     if (misses_inc == MISS_LIMIT_W) begin
                        state  <= UNLOCKED;
                        hits   <= 4'd0;
                        misses <= 4'd0;
                     end else begin
                        misses <= misses_inc;
                     end
                  end
               end
               default: begin
                  state <= UNLOCKED;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_game369_checker.sv
// tb_game369_checker
// Two checker instances share clock and reset: dut_a with default
// parameters (LOCK_LEN=2, MISS_LIMIT=3, CNT_W=8) and dut_b with
// CNT_W=2, MISS_LIMIT=15 for the counter boundary cases. A reference model
// tracks each instance with unbounded integers and the chant as a list;
// a compare process checks every output on every negedge after reset,
// and the directed sequence adds literal expectations.
module tb_game369_checker;
   import game369_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   // ---------------- DUT A ----------------
   logic       a_valid = 1'b0;
   logic [3:0] a_in = 4'd0;
   logic       a_locked, a_match, a_error, a_clap;
   logic [7:0] a_round, a_err;
   state_t     a_state;

   game369_checker #(.LOCK_LEN(2), .MISS_LIMIT(3), .CNT_W(8)) dut_a (
      .clk(clk), .reset(reset), .count_in(a_in), .count_valid(a_valid),
      .locked(a_locked), .match_pulse(a_match), .error_pulse(a_error),
      .clap(a_clap), .round_cnt(a_round), .err_cnt(a_err), .state_dbg(a_state)
   );

   // ---------------- DUT B ----------------
   logic       b_valid = 1'b0;
   logic [3:0] b_in = 4'd0;
   logic       b_locked, b_match, b_error, b_clap;
   logic [1:0] b_round, b_err;
   state_t     b_state;

   game369_checker #(.LOCK_LEN(2), .MISS_LIMIT(15), .CNT_W(2)) dut_b (
      .clk(clk), .reset(reset), .count_in(b_in), .count_valid(b_valid),
      .locked(b_locked), .match_pulse(b_match), .error_pulse(b_error),
      .clap(b_clap), .round_cnt(b_round), .err_cnt(b_err), .state_dbg(b_state)
   );

   // ---------------- scoreboard counters ----------------
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // mode: 0 = unlocked, 1 = acquiring, 2 = locked.
   int chant[5] = '{0, 3, 6, 9, 13};
   int m_lock_len[2] = '{2, 2};
   int m_miss_lim[2] = '{3, 15};
   int m_width[2]    = '{8, 2};

   int m_mode[2], m_exp[2], m_hits[2], m_miss[2], m_rounds[2], m_errs[2];
   bit m_match[2], m_err[2], m_clap[2];
   bit m_started[2] = '{1'b0, 1'b0};

   function automatic int chant_pos(input int v);
      for (int k = 0; k < 5; k++) if (chant[k] == v) return k;
      return -1;
   endfunction

   // Successor in the chant; the word after 13 is the one at position 2 (6).
   function automatic int chant_succ(input int v);
      int p;
      p = chant_pos(v);
      if (p < 0) return 0;
      return (p == 4) ? chant[2] : chant[p + 1];
   endfunction

   task automatic model_step(input int i, input bit rst, input bit v, input int c);
      bit legal;
      int was;
      m_match[i] = 0; m_err[i] = 0; m_clap[i] = 0;
      if (rst) begin
         m_mode[i] = 0; m_exp[i] = 0; m_hits[i] = 0; m_miss[i] = 0;
         m_rounds[i] = 0; m_errs[i] = 0; m_started[i] = 1;
      end else if (v) begin
         legal = (chant_pos(c) >= 0);
         m_clap[i] = legal && (c != 0);
         if (m_mode[i] == 0) begin
            if (legal) begin
               m_exp[i] = chant_succ(c); m_hits[i] = 0; m_mode[i] = 1;
            end
         end else if (m_mode[i] == 1) begin
            if (c == m_exp[i]) begin
               m_match[i] = 1; m_hits[i]++; m_exp[i] = chant_succ(m_exp[i]);
               if (m_hits[i] == m_lock_len[i]) begin m_mode[i] = 2; m_miss[i] = 0; end
            end else begin
               m_err[i] = 1; m_errs[i]++; m_hits[i] = 0;
               if (legal) m_exp[i] = chant_succ(c);
               else m_mode[i] = 0;
            end
         end else begin
            was = m_exp[i];
            m_exp[i] = chant_succ(was);
            if (c == was) begin
               m_match[i] = 1; m_miss[i] = 0;
               if (c == 13) m_rounds[i]++;
            end else begin
               m_err[i] = 1; m_errs[i]++; m_miss[i]++;
               if (m_miss[i] == m_miss_lim[i]) begin
                  m_mode[i] = 0; m_hits[i] = 0; m_miss[i] = 0;
               end
            end
         end
      end
   endtask

   function automatic int exp_round(input int i);
      return m_rounds[i] % (1 << m_width[i]);
   endfunction

   function automatic int exp_errc(input int i);
      int top;
      top = (1 << m_width[i]) - 1;
      return (m_errs[i] > top) ? top : m_errs[i];
   endfunction

   always @(posedge clk) begin
      model_step(0, reset, a_valid, int'(a_in));
      model_step(1, reset, b_valid, int'(b_in));
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (m_started[0]) begin
         check("a_locked", int'(a_locked), int'(m_mode[0] == 2));
         check("a_match",  int'(a_match),  int'(m_match[0]));
         check("a_error",  int'(a_error),  int'(m_err[0]));
         check("a_clap",   int'(a_clap),   int'(m_clap[0]));
         check("a_round",  int'(a_round),  exp_round(0));
         check("a_errcnt", int'(a_err),    exp_errc(0));
         check("a_state",  int'(a_state),  m_mode[0]);
      end
      if (m_started[1]) begin
         check("b_locked", int'(b_locked), int'(m_mode[1] == 2));
         check("b_match",  int'(b_match),  int'(m_match[1]));
         check("b_error",  int'(b_error),  int'(m_err[1]));
         check("b_clap",   int'(b_clap),   int'(m_clap[1]));
         check("b_round",  int'(b_round),  exp_round(1));
         check("b_errcnt", int'(b_err),    exp_errc(1));
         check("b_state",  int'(b_state),  m_mode[1]);
      end
   end

   // ---------------- driver tasks ----------------
   // Inputs change 1 time unit after a rising edge; outputs read here
   // reflect the sample taken at that edge.
   task automatic step_a(input bit v, input logic [3:0] c);
      a_valid = v; a_in = c;
      @(posedge clk); #1;
   endtask

   task automatic step_b(input bit v, input logic [3:0] c);
      b_valid = v; b_in = c;
      @(posedge clk); #1;
   endtask

   // ---------------- directed stimulus ----------------
   int b_err_pulses = 0;

   initial begin
      reset = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      check("reset_locked", int'(a_locked), 0);
      check("reset_errcnt", int'(a_err), 0);

      // Lock and rounds: 0,3,6 locks; 9,13 completes a round.
      step_a(1, 4'd0);  check("clap_on_0", int'(a_clap), 0);
      step_a(1, 4'd3);  check("clap_on_3", int'(a_clap), 1);
      check("not_locked_yet", int'(a_locked), 0);
      step_a(1, 4'd6);  check("locked_after_6", int'(a_locked), 1);
      step_a(1, 4'd9);
      step_a(1, 4'd13); check("round_after_13", int'(a_round), 1);
      step_a(1, 4'd6);  check("errcnt_clean", int'(a_err), 0);

      // Flywheel: expectation is 9 here.
      step_a(1, 4'd9);
      step_a(1, 4'd13);
      step_a(1, 4'd6);
      step_a(1, 4'd7);  check("fly_error", int'(a_error), 1);
      check("fly_errcnt", int'(a_err), 1);
      check("fly_locked", int'(a_locked), 1);
      step_a(1, 4'd13); check("fly_match", int'(a_match), 1);
      check("fly_round", int'(a_round), 3);

      // Unlock after three misses, then reseed from 9.
      step_a(1, 4'd5);
      step_a(1, 4'd5);  check("still_locked", int'(a_locked), 1);
      step_a(1, 4'd5);  check("unlocked", int'(a_locked), 0);
      check("unlock_errcnt", int'(a_err), 4);
      step_a(1, 4'd9);  check("seed_no_error", int'(a_error), 0);
      step_a(1, 4'd13);
      step_a(1, 4'd6);  check("relocked", int'(a_locked), 1);

      // Valid gaps with a junk word on the bus.
      step_a(0, 4'hF);  check("gap_no_clap", int'(a_clap), 0);
      check("gap_no_error", int'(a_error), 0);
      step_a(1, 4'd9);
      step_a(0, 4'hF);
      step_a(0, 4'hF);  check("gap_hold_locked", int'(a_locked), 1);
      step_a(1, 4'd13); check("gap_round", int'(a_round), 4);
      step_a(0, 4'hF);
      step_a(1, 4'd6);  check("gap_resume_match", int'(a_match), 1);

      // Drop to ACQUIRE, then reset together with a valid 6.
      step_a(1, 4'd5);
      step_a(1, 4'd5);
      step_a(1, 4'd5);
      step_a(1, 4'd0);
      step_a(1, 4'd3);
      a_valid = 1'b1; a_in = 4'd6; reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("rst_match",  int'(a_match), 0);
      check("rst_clap",   int'(a_clap), 0);
      check("rst_round",  int'(a_round), 0);
      check("rst_errcnt", int'(a_err), 0);
      step_a(1, 4'd4);  check("unlocked_illegal_ignored", int'(a_error), 0);
      step_a(1, 4'd0);
      step_a(1, 4'd9);  check("acq_reseed_error", int'(a_error), 1);
      step_a(1, 4'd13);
      step_a(1, 4'd7);  check("acq_illegal_drop", int'(a_state), 0);
      step_a(1, 4'd0);
      step_a(1, 4'd3);
      step_a(1, 4'd6);  check("relock_after_reset", int'(a_locked), 1);
      check("relock_errcnt", int'(a_err), 2);
      step_a(0, 4'd0);

      // Saturation / wrap on dut_b.
      step_b(1, 4'd0);
      step_b(1, 4'd3);
      step_b(1, 4'd6);  check("b_locked_lit", int'(b_locked), 1);
      for (int k = 0; k < 5; k++) begin
         step_b(1, 4'd5);
         if (b_error) b_err_pulses++;
      end
      check("b_err_pulses", b_err_pulses, 5);
      check("b_err_sat", int'(b_err), 3);
      check("b_still_locked", int'(b_locked), 1);
      for (int r = 1; r <= 4; r++) begin
         step_b(1, 4'd6);
         step_b(1, 4'd9);
         step_b(1, 4'd13);
         if (r == 3) check("b_round_full", int'(b_round), 3);
      end
      check("b_round_wrap", int'(b_round), 0);
      step_b(0, 4'd0);
      @(posedge clk); #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
